acc_alu: RTL

- Parametrised accumulator ALU: one WIDTH-bit accumulator register, operand/opcode accepted over a valid/ready handshake.
- Ops: AND, OR, NOT, XOR, ADD, SUB, MUL, LOAD. MUL is multi-cycle (shift-add).
- Power/ready/run/error FSM with an overflow flag.
- Sits between the operand-entry front end and the display/output mux.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/acc_alu_if.sv | 25 ++
 rtl/alu_seq_mult.sv | 71 +++++++
 rtl/acc_alu.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the accumulator ALU: FSM state encodings and opcode constants.
package alu_pkg;

    typedef enum logic [1:0] {
        S_OFF       = 2'b00,
        S_READY     = 2'b01,
        S_RUN       = 2'b10,
        S_RUN_ERROR = 2'b11
    } state_t;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_AND  = 3'd0;
    localparam opcode_t OP_OR   = 3'd1;
    localparam opcode_t OP_NOT  = 3'd2;
    localparam opcode_t OP_XOR  = 3'd3;
    localparam opcode_t OP_ADD  = 3'd4;
    localparam opcode_t OP_SUB  = 3'd5;
    localparam opcode_t OP_MUL  = 3'd6;
    localparam opcode_t OP_LOAD = 3'd7;

endpackage

// File: rtl/acc_alu_if.sv
// Op handshake and result/status bundle between the operand front end and the accumulator ALU.
interface acc_alu_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] operand;
    logic             err_clr;
    logic [WIDTH-1:0] acc_out;
    logic             result_valid;
    logic             error;
    logic [1:0]       state;

    modport master (
        output en, op_valid, opcode, operand, err_clr,
        input  op_ready, acc_out, result_valid, error, state
    );

    modport slave (
        input  en, op_valid, opcode, operand, err_clr,
        output op_ready, acc_out, result_valid, error, state
    );
endinterface

// File: rtl/alu_seq_mult.sv
// Shift-add multiplier, one multiplier bit per cycle; done_o is high in the cycle before
// the WIDTH-th edge after start, with the final partial sum folded in combinationally.
module alu_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               kill_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] step;

    assign step      = b_q[0] ? a_q : '0;
    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign product_o = prod_q + step;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        if (kill_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            a_d    = {{WIDTH{1'b0}}, a_i};
            b_d    = b_i;
            prod_d = '0;
        end else if (busy_q) begin
            if (done_o) begin
                busy_d = 1'b0;
            end else begin
                prod_d = prod_q + step;
                a_d    = a_q << 1;
                b_d    = b_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
        end
    end
endmodule

// File: rtl/acc_alu.sv
// Accumulator ALU: single-cycle logic/add/sub/load, WIDTH-cycle MUL; op_ready only in READY with en.
// Overflow wraps by default; build with ALU_SAT_EN to saturate the accumulator instead.
module acc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    acc_alu_if.slave  bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             rv_q, rv_d;
    logic             err_q, err_d;

    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] mul_res;
    logic             mul_ovf;

    assign bus.op_ready     = bus.en && (state_q == S_READY);
    assign bus.acc_out      = acc_q;
    assign bus.result_valid = rv_q;
    assign bus.error        = err_q;
    assign bus.state        = state_q;

    assign accept = bus.op_valid && bus.op_ready;
    assign sum    = {1'b0, acc_q} + {1'b0, bus.operand};
    assign diff   = {1'b0, acc_q} - {1'b0, bus.operand};

    // Dropping en kills an in-flight multiply so a stale result never lands after re-power.
    alu_seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .kill_i    (!bus.en),
        .a_i       (acc_q),
        .b_i       (bus.operand),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        alu_res = acc_q;
        alu_ovf = 1'b0;
        case (bus.opcode)
            OP_AND:  alu_res = acc_q & bus.operand;
            OP_OR:   alu_res = acc_q | bus.operand;
            OP_NOT:  alu_res = ~acc_q;
            OP_XOR:  alu_res = acc_q ^ bus.operand;
            OP_ADD: begin
                alu_ovf = sum[WIDTH];
`ifdef ALU_SAT_EN
                alu_res = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                alu_res = sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                alu_ovf = diff[WIDTH];
`ifdef ALU_SAT_EN
                alu_res = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
                alu_res = diff[WIDTH-1:0];
`endif
            end
            OP_LOAD: alu_res = bus.operand;
            default: alu_res = acc_q;
        endcase
    end

    assign mul_ovf = |mul_prod[2*WIDTH-1:WIDTH];
`ifdef ALU_SAT_EN
    assign mul_res = mul_ovf ? {WIDTH{1'b1}} : mul_prod[WIDTH-1:0];
`else
    assign mul_res = mul_prod[WIDTH-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rv_d      = 1'b0;
        err_d     = err_q && !bus.err_clr;
        mul_start = 1'b0;
        if (!bus.en) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF:   state_d = S_READY;
                S_READY: begin
                    if (accept) begin
                        if (bus.opcode == OP_MUL) begin
                            mul_start = 1'b1;
                            state_d   = S_RUN;
                        end else begin
                            acc_d = alu_res;
                            rv_d  = 1'b1;
                            if (alu_ovf) begin
                                state_d = S_RUN_ERROR;
                                err_d   = 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (mul_done) begin
                        acc_d   = mul_res;
                        rv_d    = 1'b1;
                        state_d = mul_ovf ? S_RUN_ERROR : S_READY;
                        if (mul_ovf) err_d = 1'b1;
                    end else if (!mul_busy) begin
                        state_d = S_READY;
                    end
                end
                default: state_d = S_READY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_OFF;
            acc_q   <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end
endmodule
